// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle sequencer and the datapath it steers.
// Purely structural: no latency of its own.
// No backpressure of its own; imem_ready/dmem_ready carry the memory stalls.
//
// Port summary:
//   instr, imem_ready       instruction memory read data and its valid flag
//   dmem_ready, zero        data memory completion and the ALU zero flag
//   imem_req, ir            fetch request and the latched instruction word
//   alu_op, alu_src         ALU operation code and operand-2 select
//   dmem_read, dmem_write   data memory strobes
//   reg_write, mem_to_reg   register-file write enable and writeback select
//   pc_write, pc_src        PC update enable and next-PC select
//   illegal, state          unsupported-instruction pulse and current sequencer state
interface multicycle_control_if;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        zero;

    logic        imem_req;
    logic [31:0] ir;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        dmem_read;
    logic        dmem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_write;
    logic        pc_src;
    logic        illegal;
    logic [2:0]  state;

    // The sequencer drives the control strobes.
    modport master (
        input  instr, imem_ready, dmem_ready, zero,
        output imem_req, ir, alu_op, alu_src, dmem_read, dmem_write,
               reg_write, mem_to_reg, pc_write, pc_src, illegal, state
    );

    // The datapath, memories or a bench observe the strobes.
    modport slave (
        output instr, imem_ready, dmem_ready, zero,
        input  imem_req, ir, alu_op, alu_src, dmem_read, dmem_write,
               reg_write, mem_to_reg, pc_write, pc_src, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over R/I-ALU, LW, SW, BEQ.
// BEQ 3 cycles, R/I/SW 4, LW 5, and each cycle with a memory ready low adds one.
// Stalls in FETCH until imem_ready and in MEM until dmem_ready; strobes stay asserted while stalled.
//
// Port summary:
//   clk, rst   rising-edge clock and asynchronous active-high reset
//   bus        multicycle_control_if.master: memory handshakes and zero flag in,
//              ir / ALU / memory / regfile / PC strobes and state out
module multicycle_control #(
    parameter logic [3:0]  ALU_AND   = 4'b0000,
    parameter logic [3:0]  ALU_OR    = 4'b0001,
    parameter logic [3:0]  ALU_ADD   = 4'b0010,
    parameter logic [3:0]  ALU_SUB   = 4'b0110,
    parameter logic [3:0]  ALU_SLT   = 4'b0100,
    parameter logic [3:0]  ALU_XOR   = 4'b0101,
    parameter logic [3:0]  ALU_SRL   = 4'b1000,
    parameter logic [3:0]  ALU_SLL   = 4'b1001,
    parameter logic [3:0]  ALU_SRA   = 4'b1010,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_control_if.master   bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    state_t      state_q;
    logic [31:0] ir_q;

    // ------------------------------------------------------------------
    // Decode, purely from the latched IR. ir_q is stable from DECODE until
    // the next FETCH completes, so EXEC/MEM/WB can reuse these flags
    // without storing an instruction class.
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    logic       is_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       dec_illegal;
    logic [3:0] exec_op;

    // funct3 -> ALU op; alt selects SUB for 000 and SRA for 101.
    function automatic logic [3:0] funct_to_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b010:  op = ALU_SLT;
            3'b001:  op = ALU_SLL;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    always_comb begin
        is_i        = 1'b0;
        is_lw       = 1'b0;
        is_sw       = 1'b0;
        is_beq      = 1'b0;
        dec_illegal = 1'b1;
        exec_op     = ALU_ADD;
        case (opcode)
            OPC_R: begin
                // f7=0100000 only modifies ADD->SUB and SRL->SRA.
                dec_illegal = (funct3 == 3'b011) ||
                              !((funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) &&
                                 ((funct3 == 3'b000) || (funct3 == 3'b101))));
                exec_op     = funct_to_op(funct3, funct7[5]);
            end
            OPC_I: begin
                is_i        = 1'b1;
                // Only the shift-immediates constrain the upper immediate bits.
                dec_illegal = (funct3 == 3'b011) ||
                              ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                              ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                               (funct7 != 7'b0100000));
                // ADDI has no SUBI form, so alt is only honoured for 101.
                exec_op     = funct_to_op(funct3, (funct3 == 3'b101) && funct7[5]);
            end
            OPC_LW: begin
                is_lw       = 1'b1;
                dec_illegal = (funct3 != 3'b010);
                exec_op     = ALU_ADD;
            end
            OPC_SW: begin
                is_sw       = 1'b1;
                dec_illegal = (funct3 != 3'b010);
                exec_op     = ALU_ADD;
            end
            OPC_BEQ: begin
                is_beq      = 1'b1;
                dec_illegal = (funct3 != 3'b000);
                exec_op     = ALU_SUB;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer state and instruction register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= NOP_INSTR;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        ir_q    <= bus.instr;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= dec_illegal ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    if (is_beq) begin
                        state_q <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        state_q <= is_sw ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                end
                default: begin
                    // Unused encodings recover to FETCH.
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control outputs. Derived from state/IR; the only inputs that reach
    // them are zero (BEQ target select) and dmem_ready (SW retires in MEM
    // the cycle its store completes). Everything except ir/state is
    // squashed while rst is high so an aborted instruction emits nothing.
    // ------------------------------------------------------------------
    logic       imem_req_c;
    logic [3:0] alu_op_c;
    logic       alu_src_c;
    logic       dmem_read_c;
    logic       dmem_write_c;
    logic       reg_write_c;
    logic       mem_to_reg_c;
    logic       pc_write_c;
    logic       pc_src_c;
    logic       illegal_c;

    always_comb begin
        imem_req_c   = 1'b0;
        alu_op_c     = ALU_ADD;
        alu_src_c    = 1'b0;
        dmem_read_c  = 1'b0;
        dmem_write_c = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    illegal_c  = 1'b1;
                    pc_write_c = 1'b1;
                end
            end
            S_EXEC: begin
                alu_op_c  = exec_op;
                alu_src_c = is_i || is_lw || is_sw;
                if (is_beq) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = bus.zero;
                end
            end
            S_MEM: begin
                // Keep the address operands selected while the access is pending.
                alu_src_c    = 1'b1;
                dmem_read_c  = is_lw;
                dmem_write_c = is_sw;
                pc_write_c   = is_sw && bus.dmem_ready;
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = is_lw;
                pc_write_c   = 1'b1;
            end
            default: begin
                imem_req_c = 1'b0;
            end
        endcase

        if (rst) begin
            imem_req_c   = 1'b0;
            alu_op_c     = 4'b0000;
            alu_src_c    = 1'b0;
            dmem_read_c  = 1'b0;
            dmem_write_c = 1'b0;
            reg_write_c  = 1'b0;
            mem_to_reg_c = 1'b0;
            pc_write_c   = 1'b0;
            pc_src_c     = 1'b0;
            illegal_c    = 1'b0;
        end
    end

    assign bus.imem_req   = imem_req_c;
    assign bus.ir         = ir_q;
    assign bus.alu_op     = alu_op_c;
    assign bus.alu_src    = alu_src_c;
    assign bus.dmem_read  = dmem_read_c;
    assign bus.dmem_write = dmem_write_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.illegal    = illegal_c;
    assign bus.state      = state_q;

endmodule
